spi_master_adapter: RTL and testbench
=====================================

SPI_MASTER_ADAPTER -- requirements
Module: spi_master_adapter

Interface
REQ-001 Parameter ADD_range, default 7: register address width; header = {rw, addr}, zero-padded on the left to 8 bits; legal range 1..7.
REQ-002 Parameter CLK_DIV, default 4: SCA_spi half-period in clk cycles; legal values >= 1.
REQ-003 Parameter CS_GAP, default 2: number of clk cycles CS_spi stays high between bytes; legal values >= 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 rw  input  1  1 = read, 0 = write; captured with start.
REQ-008 addr  input  ADD_range  register address; captured with start.
REQ-009 wdata  input  24  write payload; captured with start.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse at the end of a transaction.
REQ-012 rdata  output  24  MISO bits from data bytes 1..3, MSB first; held until the next accepted start.
REQ-013 SCA_spi  output  1  SPI clock; idles low.
REQ-014 MOSI_spi  output  1  serial data to the slave.
REQ-015 CS_spi  output  1  active-low chip select; idles high.
REQ-016 MISO_spi  input  1  serial data from the slave, which updates it on the SCA_spi rising edge.

Function
REQ-017 FSM states: IDLE, CS_SETUP, SHIFT, GAP, DONE.
- IDLE -> CS_SETUP on start.
- CS_SETUP -> SHIFT after CLK_DIV cycles.
- SHIFT -> GAP after 8 bits.
- GAP -> CS_SETUP after CS_GAP cycles while bytes remain; GAP -> DONE after byte 3.
- DONE -> IDLE after one cycle.
REQ-018 A transaction is 4 bytes, each sent MSB first: byte 0 = header, then wdata[23:16], wdata[15:8], wdata[7:0].
REQ-019 Bytes are framed individually: CS_spi goes low for CS_SETUP+SHIFT of each byte, then high for GAP, giving 4 CS low windows per transaction.
REQ-020 Bit timing: each bit spends CLK_DIV cycles with SCA_spi low, then CLK_DIV cycles with SCA_spi high.
- MOSI_spi changes only at the start of a low half.
- MISO_spi is sampled on the high-to-low SCA_spi transition that ends each bit.
REQ-021 Byte timing: each byte lasts 17*CLK_DIV cycles with CS_spi low (CLK_DIV setup plus 16*CLK_DIV shift).
REQ-022 Latency: start is sampled at edge k; CS_spi goes low at k+1. At k+68*CLK_DIV+3*CS_GAP+1, CS_spi returns high, done pulses and rdata updates.
REQ-023 rdata is captured on reads and on writes; its value after a write is whatever MISO_spi carried.
REQ-024 start while busy is ignored; start in the DONE cycle is ignored; start one cycle after done is accepted.
REQ-025 The inputs rw, addr and wdata are don't-care after the start cycle.
REQ-026 MOSI_spi is 0 whenever CS_spi is high.

Reset
REQ-027 While reset is low, outputs are forced asynchronously to: CS_spi=1, SCA_spi=0, MOSI_spi=0, busy=0, done=0, rdata=0; state=IDLE; all counters=0.
REQ-028 A reset asserted mid-transaction aborts the transaction with no done pulse; the first start after reset deasserts begins a fresh transaction.

Structure
REQ-029 Package spi_master_pkg holds:
- the FSM state enum;
- HDR_W=8, DATA_BYTES=3, BYTE_W=8.
REQ-030 Sub-module spi_clk_gen (parameter CLK_DIV) holds the half-period counter and issues one-cycle rise_tick and fall_tick strobes; the FSM uses these strobes and never owns an SCA_spi counter.

Verification
REQ-031 Write rw=0, addr=7'h15, wdata=24'hA5C30F -> MOSI_spi bytes 0x15, 0xA5, 0xC3, 0x0F; 4 CS_spi low windows; 32 SCA_spi rising edges; one done pulse.
REQ-032 Read rw=1, addr=7'h03, with a slave model driving MISO bytes 0xAA, 0xAA, 0xAA on the data bytes -> header byte 0x83; rdata=24'hAAAAAA at done.
REQ-033 CLK_DIV=2, CS_GAP=2, start at cycle 0 -> done high at cycle 143; busy high over cycles 1..142.
REQ-034 start pulsed during byte 2 -> no effect: output waveforms are identical to the single-start run.
REQ-035 reset asserted mid-SHIFT of byte 1 -> outputs take reset values immediately; no done pulse. A new write after release produces a complete, correct 4-byte frame.
REQ-036 start one cycle after done -> second transaction begins with CS_spi low on the following cycle; both transactions are bit-correct.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and frame geometry for the SPI master adapter.
package spi_master_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, GAP, DONE} state_e;

  localparam int HDR_W      = 8;
  localparam int DATA_BYTES = 3;
  localparam int BYTE_W     = 8;
  localparam int FRAME_W    = HDR_W + DATA_BYTES * BYTE_W;
endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock phase generator: counts half periods while enabled and strobes
// the low->high and high->low SCA transitions.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == HALF_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_tick = en && (cnt_q == HALF_LAST) && !phase_q;
  assign fall_tick = en && (cnt_q == HALF_LAST) &&  phase_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/spi_master_adapter.sv
// Register-access SPI master: 4-byte transaction (header + 24-bit payload),
// each byte framed by its own CS low window, MISO captured into rdata.
module spi_master_adapter
  import spi_master_pkg::*;
#(
  parameter int ADD_range = 7,
  parameter int CLK_DIV   = 4,
  parameter int CS_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rw,
  input  logic [ADD_range-1:0] addr,
  input  logic [23:0]          wdata,
  output logic                 busy,
  output logic                 done,
  output logic [23:0]          rdata,
  output logic                 SCA_spi,
  output logic                 MOSI_spi,
  output logic                 CS_spi,
  input  logic                 MISO_spi
);
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam int RX_W = DATA_BYTES * BYTE_W;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           byte_q, byte_d;
  logic [2:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [RX_W-1:0]      rx_q, rx_d, rdata_q, rdata_d;
  logic                 sca_q, sca_d, mosi_q, mosi_d, cs_q, cs_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [HDR_W-1:0]     hdr;
  logic                 rise_tick, fall_tick;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (state_q == SHIFT),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    hdr                = '0;
    hdr[ADD_range:0]   = {rw, addr};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sca_d   = sca_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (start) begin
        tx_d    = {hdr, wdata};
        mosi_d  = hdr[HDR_W-1];
        cs_d    = 1'b0;
        busy_d  = 1'b1;
        cnt_d   = '0;
        byte_d  = '0;
        bit_d   = '0;
        state_d = CS_SETUP;
      end
      CS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else cnt_d = cnt_q + 1'b1;
      end
      SHIFT: begin
        if (rise_tick) sca_d = 1'b1;
        // Falling edge closes a bit: sample MISO, advance MOSI to the next bit.
        if (fall_tick) begin
          sca_d = 1'b0;
          rx_d  = {rx_q[RX_W-2:0], MISO_spi};
          tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
          if (bit_q == 3'(BYTE_W - 1)) begin
            bit_d  = '0;
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            if (byte_q == 2'(DATA_BYTES)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              rdata_d = {rx_q[RX_W-2:0], MISO_spi};
              state_d = DONE;
            end else begin
              byte_d  = byte_q + 1'b1;
              cnt_d   = '0;
              state_d = GAP;
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            mosi_d = tx_q[FRAME_W-2];
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b0;
          mosi_d  = tx_q[FRAME_W-1];
          state_d = CS_SETUP;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sca_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sca_q   <= sca_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign SCA_spi  = sca_q;
  assign MOSI_spi = mosi_q;
  assign CS_spi   = cs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
endmodule

// File: tb/tb_spi_master_adapter.sv
// Self-checking bench: table vectors plus random transactions against a
// cycle-offset waveform model and a byte-level MOSI/MISO slave.
module tb_spi_master_adapter;
  localparam int CD = 2;
  localparam int CG = 2;
  localparam int N  = 68 * CD + 3 * CG;
  localparam int P  = 17 * CD + CG;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, rw = 1'b0, MISO_spi = 1'b0;
  logic [6:0]  addr = '0;
  logic [23:0] wdata = '0;
  logic        busy, done, SCA_spi, MOSI_spi, CS_spi;
  logic [23:0] rdata;
  int n_cmp = 0, n_fail = 0;

  spi_master_adapter #(.ADD_range(7), .CLK_DIV(CD), .CS_GAP(CG)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .SCA_spi(SCA_spi),
    .MOSI_spi(MOSI_spi), .CS_spi(CS_spi), .MISO_spi(MISO_spi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rw; logic [6:0] addr; logic [23:0] wdata; logic [23:0] miso; int mode;
    logic [31:0] exp_mosi; logic [23:0] exp_rdata;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Expected {CS, SCA, MOSI, busy, done} t cycles after the accepting edge.
  function automatic logic [4:0] model(input int t, input logic [31:0] fr);
    int u, b, r, s;
    logic cs, sca, mo, bz, dn;
    cs = 1'b1; sca = 1'b0; mo = 1'b0; bz = 1'b0; dn = 1'b0;
    if (t >= 1 && t <= N) begin
      bz = 1'b1; u = t - 1; b = u / P; r = u % P;
      if (r < 17 * CD) begin
        cs = 1'b0;
        if (r < CD) mo = fr[31 - 8 * b];
        else begin
          s   = r - CD;
          sca = (s % (2 * CD)) >= CD;
          mo  = fr[31 - 8 * b - s / (2 * CD)];
        end
      end
    end else if (t == N + 1) dn = 1'b1;
    return {cs, sca, mo, bz, dn};
  endfunction

  // mode 0: plain; 1: extra start during byte 2; 2: extra start in the done cycle
  task automatic run_txn(input logic r, input logic [6:0] a, input logic [23:0] w,
                         input logic [23:0] m, input int mode,
                         input logic [31:0] exp_mosi, input logic [23:0] exp_rd);
    logic [31:0] sbits, got;
    logic [4:0]  act, exp, bad_act, bad_exp;
    logic [23:0] rd_at_done;
    logic        p_cs, p_sca;
    int rises, wins, dones, done_t, bad, bad_t;
    sbits = {8'($urandom), m};
    got = '0; rd_at_done = 'x; rises = 0; wins = 0; dones = 0; done_t = -1;
    bad = 0; bad_t = 0; bad_act = '0; bad_exp = '0; p_cs = 1'b1; p_sca = 1'b0;
    rw = r; addr = a; wdata = w; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; rw = 1'($urandom); addr = 7'($urandom); wdata = 24'($urandom);
    for (int t = 1; t <= N + 2; t++) begin
      @(negedge clk);
      act = {CS_spi, SCA_spi, MOSI_spi, busy, done};
      exp = model(t, exp_mosi);
      if (act !== exp) begin
        if (bad == 0) begin bad_t = t; bad_act = act; bad_exp = exp; end
        bad++;
      end
      if (p_cs && !CS_spi) wins++;
      if (!p_sca && SCA_spi) begin
        got = {got[30:0], MOSI_spi};
        if (rises < 32) MISO_spi = sbits[31 - rises];
        rises++;
      end
      p_cs = CS_spi; p_sca = SCA_spi;
      if (done === 1'b1) begin dones++; done_t = t; rd_at_done = rdata; end
      if (mode == 1 && t == 2 * P + CD + 4) start = 1'b1;
      if (mode == 1 && t == 2 * P + CD + 5) start = 1'b0;
      if (mode == 2 && t == N + 1) begin start = 1'b1; rw = 1'b1; addr = 7'h55; end
      if (mode == 2 && t == N + 2) start = 1'b0;
    end
    MISO_spi = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL waveform: %0d cycles differ, first t=%0d got %b want %b",
               bad, bad_t, bad_act, bad_exp);
    end
    chk("mosi_bytes", 64'(got), 64'(exp_mosi));
    chk("cs_windows", 64'(wins), 64'd4);
    chk("sca_rises", 64'(rises), 64'd32);
    chk("done_pulses", 64'(dones), 64'd1);
    chk("done_latency", 64'(done_t), 64'(N + 1));
    chk("rdata_at_done", 64'(rd_at_done), 64'(exp_rd));
    chk("rdata_hold", 64'(rdata), 64'(exp_rd));
  endtask

  initial begin
    logic [23:0] rw_d, rm;
    logic [6:0]  ra;
    logic        rr;
    int          dseen, csl;

    tbl[0] = '{1'b0, 7'h15, 24'hA5C30F, 24'h000000, 0, 32'h15A5C30F, 24'h000000};
    tbl[1] = '{1'b1, 7'h03, 24'h000000, 24'hAAAAAA, 0, 32'h83000000, 24'hAAAAAA};
    tbl[2] = '{1'b0, 7'h15, 24'hA5C30F, 24'h000000, 1, 32'h15A5C30F, 24'h000000};
    tbl[3] = '{1'b1, 7'h7F, 24'hFFFFFF, 24'h5A3C81, 2, 32'hFFFFFFFF, 24'h5A3C81};
    tbl[4] = '{1'b0, 7'h00, 24'h000001, 24'h800001, 0, 32'h00000001, 24'h800001};
    tbl[5] = '{1'b1, 7'h2A, 24'h123456, 24'h0F0F0F, 0, 32'hAA123456, 24'h0F0F0F};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {CS_spi, SCA_spi, MOSI_spi, busy, done, rdata},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0});
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back: each transaction's start is raised the cycle after done.
    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].miso, tbl[i].mode,
              tbl[i].exp_mosi, tbl[i].exp_rdata);

    // Abort mid-SHIFT of byte 1 with an asynchronous reset.
    rw = 1'b0; addr = 7'h11; wdata = 24'h3C3C3C; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t <= P + CD + 3; t++) @(negedge clk);
    chk("cs_low_before_abort", 64'(CS_spi), 64'd0);
    #2 reset = 1'b0;
    #1 chk("abort_outputs", {CS_spi, SCA_spi, MOSI_spi, busy, done, rdata},
           {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dseen = 0; csl = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done !== 1'b0) dseen++;
      if (CS_spi !== 1'b1) csl++;
    end
    chk("post_abort_quiet", 64'(dseen + csl), 64'd0);
    run_txn(1'b0, 7'h15, 24'hA5C30F, 24'h000000, 0, 32'h15A5C30F, 24'h000000);

    for (int i = 0; i < 8; i++) begin
      rr = 1'($urandom); ra = 7'($urandom); rw_d = 24'($urandom); rm = 24'($urandom);
      run_txn(rr, ra, rw_d, rm, int'($urandom_range(0, 1)), {rr, ra, rw_d}, rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
